// File: rtl/atm_pkg.sv
// Shared codes for the ATM transaction controller: FSM state, operation and error encodings.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PIN = 3'd1,
    ST_CHECK    = 3'd2,
    ST_MENU     = 3'd3,
    ST_EXEC     = 3'd4,
    ST_EJECT    = 3'd5,
    ST_LOCKED   = 3'd6
  } atm_state_e;

  typedef enum logic [1:0] {
    OP_INQUIRY  = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_EXIT     = 2'b11
  } atm_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_WRONG_PIN = 2'b01,
    ERR_NO_FUNDS  = 2'b10,
    ERR_OVERFLOW  = 2'b11
  } atm_err_e;

endpackage

// File: rtl/atm_txn_controller_if.sv
// Bus between the keypad/card front end plus account store (master) and the controller (slave).
interface atm_txn_if #(
  parameter int balance_width = 20
);
  // Strobe protocol: pin_enter and op_req are single-cycle requests with no backpressure;
  // their qualifiers (wrong_psw, op_sel, amount) are valid in the strobe cycle. op_done and
  // eject are single-cycle registered strobes; updated_balance is valid whenever op_done is high.
  logic                     card_in;
  logic                     pin_enter;
  logic                     wrong_psw;
  logic [balance_width-1:0] balance_in;
  logic                     op_req;
  logic [1:0]               op_sel;
  logic [balance_width-1:0] amount;
  logic                     op_done;
  logic [balance_width-1:0] updated_balance;
  logic [balance_width-1:0] balance_out;
  logic [1:0]               err_code;
  logic                     authed;
  logic                     card_retained;
  logic                     eject;
  logic [2:0]               state;

  modport master (
    output card_in, pin_enter, wrong_psw, balance_in, op_req, op_sel, amount,
    input  op_done, updated_balance, balance_out, err_code, authed, card_retained, eject, state
  );

  modport slave (
    input  card_in, pin_enter, wrong_psw, balance_in, op_req, op_sel, amount,
    output op_done, updated_balance, balance_out, err_code, authed, card_retained, eject, state
  );
endinterface

// File: rtl/atm_timeout_timer.sv
// Inactivity counter: counts while run is high, clears on reload or when not running,
// and flags expired in the timeout_cycles-th consecutive running cycle.
module atm_timeout_timer #(
  parameter int timeout_cycles = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expired
);
  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

  logic [CW-1:0] count;

  assign expired = run && !reload && (count == CW'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!run || reload || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/atm_txn_controller.sv
// ATM session sequencer: PIN check with retry lockout, then inquiry/deposit/withdraw with write-back.
// Optional inactivity timeout in WAIT_PIN/MENU is built when ATM_TIMEOUT_EN is defined.
module atm_txn_controller
  import atm_pkg::*;
#(
  parameter int balance_width  = 20,
  parameter int max_attempts   = 3,
  parameter int timeout_cycles = 1000
) (
  input logic      clk,
  input logic      rst,
  atm_txn_if.slave bus
);
  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] WAIT_PIN = ST_WAIT_PIN;
  localparam logic [2:0] CHECK    = ST_CHECK;
  localparam logic [2:0] MENU     = ST_MENU;
  localparam logic [2:0] EXEC     = ST_EXEC;
  localparam logic [2:0] EJECT    = ST_EJECT;
  localparam logic [2:0] LOCKED   = ST_LOCKED;
  localparam int AW = $clog2(max_attempts + 1);

  logic [2:0]               state, state_nx;
  logic [AW-1:0]            attempts, attempts_inc;
  logic [1:0]               op_q;
  logic [balance_width-1:0] amount_q;
  logic [balance_width-1:0] upd_bal, disp_bal;
  logic [balance_width:0]   dep_sum;
  logic                     wd_short;
  logic                     op_done_q, eject_q, authed_q, retained_q;
  logic [1:0]               err_q;
  logic                     timeout_hit;

  assign attempts_inc = attempts + 1'b1;
  assign dep_sum      = {1'b0, upd_bal} + {1'b0, amount_q};
  assign wd_short     = amount_q > upd_bal;

`ifdef ATM_TIMEOUT_EN
  logic timer_run, timer_reload;
  assign timer_run    = (state == WAIT_PIN) || (state == MENU);
  assign timer_reload = bus.pin_enter || bus.op_req;

  atm_timeout_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (timer_run),
    .reload (timer_reload),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Card removal outranks every request; LOCKED deliberately ignores card_in.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.card_in) state_nx = WAIT_PIN;
      WAIT_PIN: begin
        if (!bus.card_in)       state_nx = IDLE;
        else if (bus.pin_enter) state_nx = CHECK;
        else if (timeout_hit)   state_nx = EJECT;
      end
      CHECK: begin
        if (!bus.card_in)                          state_nx = IDLE;
        else if (!bus.wrong_psw)                   state_nx = MENU;
        else if (attempts_inc >= AW'(max_attempts)) state_nx = LOCKED;
        else                                       state_nx = WAIT_PIN;
      end
      MENU: begin
        if (!bus.card_in)     state_nx = IDLE;
        else if (bus.op_req)  state_nx = (bus.op_sel == OP_EXIT) ? EJECT : EXEC;
        else if (timeout_hit) state_nx = EJECT;
      end
      EXEC:     state_nx = bus.card_in ? MENU : IDLE;
      EJECT:    if (!bus.card_in) state_nx = IDLE;
      LOCKED:   state_nx = LOCKED;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      attempts   <= '0;
      op_q       <= OP_INQUIRY;
      amount_q   <= '0;
      upd_bal    <= '0;
      disp_bal   <= '0;
      op_done_q  <= 1'b0;
      eject_q    <= 1'b0;
      authed_q   <= 1'b0;
      retained_q <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state      <= state_nx;
      op_done_q  <= 1'b0;
      eject_q    <= (state_nx == EJECT) && (state != EJECT);
      authed_q   <= (state_nx == MENU) || (state_nx == EXEC);
      retained_q <= (state_nx == LOCKED);
      if (state != IDLE && state_nx == IDLE) err_q <= ERR_NONE;

      case (state)
        IDLE: if (bus.card_in) attempts <= '0;
        CHECK: if (bus.card_in) begin
          if (!bus.wrong_psw) begin
            upd_bal  <= bus.balance_in;
            disp_bal <= bus.balance_in;
            attempts <= '0;
            err_q    <= ERR_NONE;
          end else begin
            attempts <= attempts_inc;
            err_q    <= ERR_WRONG_PIN;
          end
        end
        MENU: if (bus.card_in && bus.op_req) begin
          op_q     <= bus.op_sel;
          amount_q <= bus.amount;
        end
        // A commit is only issued while the card is still present.
        EXEC: if (bus.card_in) begin
          case (op_q)
            OP_INQUIRY: begin
              disp_bal <= upd_bal;
              err_q    <= ERR_NONE;
            end
            OP_DEPOSIT: begin
              if (dep_sum[balance_width]) begin
                err_q <= ERR_OVERFLOW;
              end else begin
                upd_bal   <= dep_sum[balance_width-1:0];
                disp_bal  <= dep_sum[balance_width-1:0];
                op_done_q <= 1'b1;
                err_q     <= ERR_NONE;
              end
            end
            OP_WITHDRAW: begin
              if (wd_short) begin
                err_q <= ERR_NO_FUNDS;
              end else begin
                upd_bal   <= upd_bal - amount_q;
                disp_bal  <= upd_bal - amount_q;
                op_done_q <= 1'b1;
                err_q     <= ERR_NONE;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.state           = state;
  assign bus.op_done         = op_done_q;
  assign bus.updated_balance = upd_bal;
  assign bus.balance_out     = disp_bal;
  assign bus.err_code        = err_q;
  assign bus.authed          = authed_q;
  assign bus.card_retained   = retained_q;
  assign bus.eject           = eject_q;
endmodule

// File: tb/tb_atm_txn_controller.sv
// Directed bench for atm_txn_controller: commits and ejects are checked by a monitor against
// queued expectations; session state, errors and balances are checked after each step.
module tb_atm_txn_controller;
  import atm_pkg::*;

  localparam int BW = 20;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  atm_txn_if #(.balance_width(BW)) bus ();

  atm_txn_controller #(
    .balance_width (BW),
    .max_attempts  (3),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];
  int eject_pending = 0;
  logic [BW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every commit strobe must match the oldest queued write-back value.
  always @(negedge clk) begin
    if (rst && bus.op_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected: got op_done with updated_balance %0d expected no commit",
                 bus.updated_balance);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.updated_balance !== mon_exp || bus.balance_out !== mon_exp) begin
          bad++;
          $display("FAIL commit_value: got updated %0d shown %0d expected %0d",
                   bus.updated_balance, bus.balance_out, mon_exp);
        end
      end
    end
    if (rst && bus.eject) begin
      total++;
      if (eject_pending == 0) begin
        bad++;
        $display("FAIL eject_unexpected: got eject=1 expected 0");
      end else begin
        eject_pending--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert_card(input logic [BW-1:0] bal);
    bus.card_in    = 1'b1;
    bus.balance_in = bal;
    tick(1);
  endtask

  task automatic enter_pin(input logic wrong);
    bus.pin_enter = 1'b1;
    bus.wrong_psw = wrong;
    tick(1);
    bus.pin_enter = 1'b0;
    tick(1);
  endtask

  task automatic do_op(input logic [1:0] sel, input logic [BW-1:0] amt,
                       input logic commit, input logic [BW-1:0] exp_val);
    if (commit) exp_q.push_back(exp_val);
    if (sel == OP_EXIT) eject_pending++;
    bus.op_req = 1'b1;
    bus.op_sel = sel;
    bus.amount = amt;
    tick(1);
    bus.op_req = 1'b0;
    tick(1);
  endtask

  task automatic remove_card();
    bus.card_in = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    bus.card_in = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.card_in    = 1'b0;
    bus.pin_enter  = 1'b0;
    bus.wrong_psw  = 1'b0;
    bus.balance_in = '0;
    bus.op_req     = 1'b0;
    bus.op_sel     = 2'b00;
    bus.amount     = '0;
    tick(2);

    check("rst_state", bus.state, ST_IDLE);
    check("rst_op_done", bus.op_done, 0);
    check("rst_eject", bus.eject, 0);
    check("rst_authed", bus.authed, 0);
    check("rst_retained", bus.card_retained, 0);
    check("rst_err", bus.err_code, ERR_NONE);
    check("rst_updated", bus.updated_balance, 0);
    check("rst_balance_out", bus.balance_out, 0);
    rst = 1'b1;
    tick(1);

    // Stray strobes outside their states
    bus.pin_enter = 1'b1;
    tick(1);
    bus.pin_enter = 1'b0;
    check("pin_in_idle", bus.state, ST_IDLE);
    insert_card(20'd1000);
    check("card_to_wait_pin", bus.state, ST_WAIT_PIN);
    bus.op_req = 1'b1; bus.op_sel = OP_WITHDRAW; bus.amount = 20'd5;
    tick(1);
    bus.op_req = 1'b0;
    check("op_in_wait_pin", bus.state, ST_WAIT_PIN);

    enter_pin(1'b0);
    check("pin_ok_state", bus.state, ST_MENU);
    check("pin_ok_authed", bus.authed, 1);
    check("pin_ok_balance_out", bus.balance_out, 1000);
    check("pin_ok_updated", bus.updated_balance, 1000);

    do_op(OP_WITHDRAW, 20'd300, 1'b1, 20'd700);
    check("wd300_updated", bus.updated_balance, 700);
    check("wd300_err", bus.err_code, ERR_NONE);
    check("wd300_state", bus.state, ST_MENU);
    do_op(OP_DEPOSIT, 20'd300, 1'b1, 20'd1000);
    do_op(OP_WITHDRAW, 20'd1500, 1'b0, '0);
    check("wd1500_err", bus.err_code, ERR_NO_FUNDS);
    check("wd1500_updated", bus.updated_balance, 1000);
    check("wd1500_balance_out", bus.balance_out, 1000);
    do_op(OP_WITHDRAW, 20'd0, 1'b1, 20'd1000);
    check("wd0_err", bus.err_code, ERR_NONE);
    do_op(OP_INQUIRY, 20'd0, 1'b0, '0);
    check("inquiry_balance_out", bus.balance_out, 1000);
    do_op(OP_EXIT, 20'd0, 1'b0, '0);
    check("exit_state", bus.state, ST_EJECT);
    check("exit_authed", bus.authed, 0);
    remove_card();
    check("eject_to_idle", bus.state, ST_IDLE);

    // Overflow boundary at 2^20-1
    insert_card(20'd1048570);
    enter_pin(1'b0);
    do_op(OP_DEPOSIT, 20'd10, 1'b0, '0);
    check("dep10_err", bus.err_code, ERR_OVERFLOW);
    check("dep10_updated", bus.updated_balance, 1048570);
    do_op(OP_DEPOSIT, 20'd5, 1'b1, 20'd1048575);
    check("dep5_err", bus.err_code, ERR_NONE);
    check("dep5_balance_out", bus.balance_out, 1048575);
    do_op(OP_WITHDRAW, 20'd100, 1'b1, 20'd1048475);

    // Card pulled during EXEC of a deposit
    bus.op_req = 1'b1; bus.op_sel = OP_DEPOSIT; bus.amount = 20'd50;
    tick(1);
    bus.op_req  = 1'b0;
    bus.card_in = 1'b0;
    tick(1);
    check("pull_exec_state", bus.state, ST_IDLE);
    check("pull_exec_updated", bus.updated_balance, 1048475);
    check("pull_exec_err", bus.err_code, ERR_NONE);
    tick(2);

    // Asynchronous reset in the middle of EXEC
    insert_card(20'd100);
    enter_pin(1'b0);
    bus.op_req = 1'b1; bus.op_sel = OP_DEPOSIT; bus.amount = 20'd1;
    tick(1);
    bus.op_req  = 1'b0;
    #2 rst = 1'b0;
    bus.card_in = 1'b0;
    tick(1);
    check("rst_exec_updated", bus.updated_balance, 0);
    check("rst_exec_state", bus.state, ST_IDLE);
    rst = 1'b1;
    tick(1);

    // Three wrong PINs lock the card
    insert_card(20'd500);
    enter_pin(1'b1);
    check("wrong1_err", bus.err_code, ERR_WRONG_PIN);
    check("wrong1_state", bus.state, ST_WAIT_PIN);
    enter_pin(1'b1);
    check("wrong2_err", bus.err_code, ERR_WRONG_PIN);
    check("wrong2_retained", bus.card_retained, 0);
    enter_pin(1'b1);
    check("wrong3_err", bus.err_code, ERR_WRONG_PIN);
    check("wrong3_state", bus.state, ST_LOCKED);
    check("wrong3_retained", bus.card_retained, 1);
    check("wrong3_authed", bus.authed, 0);
    bus.card_in = 1'b0; tick(3);
    bus.card_in = 1'b1; tick(3);
    bus.card_in = 1'b0; tick(2);
    check("locked_hold_state", bus.state, ST_LOCKED);
    check("locked_hold_retained", bus.card_retained, 1);
    do_reset();
    check("unlock_retained", bus.card_retained, 0);
    check("unlock_state", bus.state, ST_IDLE);

    // Wrong, wrong, correct; then a new card gets three fresh attempts
    insert_card(20'd200);
    enter_pin(1'b1);
    enter_pin(1'b1);
    enter_pin(1'b0);
    check("wwc_state", bus.state, ST_MENU);
    check("wwc_err", bus.err_code, ERR_NONE);
    check("wwc_balance_out", bus.balance_out, 200);
    do_op(OP_EXIT, 20'd0, 1'b0, '0);
    remove_card();
    insert_card(20'd200);
    enter_pin(1'b1);
    enter_pin(1'b1);
    check("fresh2_state", bus.state, ST_WAIT_PIN);
    check("fresh2_retained", bus.card_retained, 0);
    enter_pin(1'b1);
    check("fresh3_state", bus.state, ST_LOCKED);
    do_reset();

    // Idle session in MENU
    insert_card(20'd300);
    enter_pin(1'b0);
`ifdef ATM_TIMEOUT_EN
    begin
      logic got;
      got = 1'b0;
      eject_pending++;
      for (int i = 0; i < 20 && !got; i++) begin
        tick(1);
        if (bus.eject) got = 1'b1;
      end
      check("timeout_eject_seen", got, 1);
      check("timeout_state", bus.state, ST_EJECT);
    end
`else
    tick(20);
    check("no_timeout_state", bus.state, ST_MENU);
`endif
    remove_card();
    tick(2);

    check("commit_queue_empty", exp_q.size(), 0);
    check("eject_pending_zero", eject_pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
